video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Parametrised test-pattern source for the video output path. Generates a frame of `H_ACTIVE` x `V_ACTIVE` RGB pixels with a run-time selectable pattern: tile checkerboard, colour bars, solid fill, or an optional gradient. Sits upstream of the display/video encoder and drives pixels under a valid/ready handshake, with frame and line markers. It replaces the fixed 4-colour tile generator wherever a configurable bring-up or test source is needed.

## Interface
- `H_ACTIVE`, 800, active pixels per line; must be ≥ 8 and divisible by 8.
- `V_ACTIVE`, 600, active lines per frame; ≥ 2.
- `TILE_W`, 80, checkerboard tile width in pixels; 1..`H_ACTIVE`.
- `TILE_H`, 200, checkerboard tile height in lines; 1..`V_ACTIVE`.
- `COLOR_W`, 8, bits per colour channel; pixel is `3*COLOR_W` bits, ordered {R,G,B}.

Ports:
- `Clock`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Mode`  in  2  pattern select: 0 checker, 1 bars, 2 solid, 3 gradient.
- `VideoReady`  in  1  sink accepts the current pixel.
- `VideoValid`  out  1  pixel on `video` is valid.
- `video`  out  3*COLOR_W  current pixel {R,G,B}.
- `StartOfFrame`  out  1  high with pixel (0,0).
- `EndOfLine`  out  1  high with pixel x = `H_ACTIVE`-1.

## Operation
- Position counters: x in 0..`H_ACTIVE`-1, y in 0..`V_ACTIVE`-1. A transfer is a cycle with `VideoValid && VideoReady`. Each transfer advances x. x wraps to 0 and increments y. y wraps to 0 after the last line.
- Sub-counters replace division: tile column count, tile row count, and bar index with width `H_ACTIVE/8`. Each resets at the corresponding wrap.
- Active mode register is loaded from `Mode` at reset release and on the transfer of the last pixel of a frame. `Mode` changes mid-frame are ignored.
- Mode 0, checker: tx = x / `TILE_W`, ty = y / `TILE_H`. Palette index {ty[0], tx[0]}: 00 TURQUOISE {26,188,156}, 01 CARROT {230,126,34}, 10 SUNFLOWER {241,196,15}, 11 EMERALD {46,204,113}. Values are for `COLOR_W`=8. For other widths, values are MSB-aligned: shift left or truncate the low bits.
- Mode 1, bars: bar b = x / (`H_ACTIVE`/8). b = 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black. Channel full-scale is all ones; zero is 0.
- Mode 2, solid: TURQUOISE on every pixel.
- Mode 3: see Configuration.
- Partial last tile (`H_ACTIVE` not a multiple of `TILE_W`) is truncated; the next line restarts at tx = 0.

## Timing
- Reset values: `VideoValid`=0, `video`=0, `StartOfFrame`=0, `EndOfLine`=0, x=y=0, all sub-counters 0, mode register 0.
- First cycle after `Reset` deasserts: `VideoValid`=1, pixel (0,0) on `video`, `StartOfFrame`=1.
- All outputs are registered. The next pixel is computed from next-state counters, so a new pixel appears the cycle after each transfer. Throughput is 1 pixel/cycle when `VideoReady` is held high.
- Backpressure: while `VideoReady`=0, `video`, `StartOfFrame`, `EndOfLine` and the counters hold unchanged.
- `VideoValid` stays 1 from the first post-reset cycle until the next `Reset`; it never drops between frames.
- Reset asserted mid-frame: takes effect on that clock edge. Any pending transfer in that cycle is discarded.

## Configuration
- `PATGEN_GRADIENT_EN` defined: mode 3 is a gradient. R = x[COLOR_W-1:0], G = y[COLOR_W-1:0], B = MSB-only value (8'h80 at width 8).
- Not defined: mode 3 behaves exactly as mode 2 (solid TURQUOISE), and no gradient logic is synthesised.

## Structure
- Shared package `video_pkg`: mode encoding localparams, the palette constants (TURQUOISE, CARROT, SUNFLOWER, EMERALD), the 8 bar colours, and the pixel width function `3*COLOR_W`.
- One sub-module, `video_pos_counter`. It holds the x/y counters, tile and bar sub-counters, and end-of-line/end-of-frame flags, and is enabled by transfer. The top level does mode latching, colour selection and output registers.

## Test plan
- Reset release, mode 0, `VideoReady`=1 → cycle 1 pixel {26,188,156} with `StartOfFrame`=1. Transfer 80 gives {230,126,34}. Pixel (0,200) gives {241,196,15}. Pixel (80,200) gives {46,204,113}.
- Mode 1, defaults → x=0 white, x=100 yellow, x=799 black. `EndOfLine`=1 only at x=799.
- `VideoReady` toggles 0 for 5 cycles at x=79 → `video` holds CARROT-neighbour value TURQUOISE unchanged. No pixel is skipped; x=80 is CARROT after release.
- Change `Mode` 0→1 at pixel (400,300) → mode-0 pixels continue until (799,599). Pixel (0,0) of the next frame is white with `StartOfFrame`=1 after 480000 transfers.
- Mode 3 with and without `PATGEN_GRADIENT_EN` → pixel (300,5) is {44,5,128} when defined, {26,188,156} when not.
- `Reset` pulsed at (123,45) → next cycle `VideoValid`=0 and all outputs 0. Cycle after release restarts at (0,0) with `StartOfFrame`=1.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared definitions for the video test-pattern source:
//                pattern-mode encodings, the 8-bit reference palette, the
//                colour-bar table and the pixel width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

  // Pattern select encodings
  localparam logic [1:0] MODE_CHECKER  = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_SOLID    = 2'd2;
  localparam logic [1:0] MODE_GRADIENT = 2'd3;

  // Reference palette, {R,G,B} at 8 bits per channel
  localparam logic [23:0] TURQUOISE = {8'd26,  8'd188, 8'd156};
  localparam logic [23:0] CARROT    = {8'd230, 8'd126, 8'd34};
  localparam logic [23:0] SUNFLOWER = {8'd241, 8'd196, 8'd15};
  localparam logic [23:0] EMERALD   = {8'd46,  8'd204, 8'd113};

  // Colour bars as {R,G,B} on/off flags; each flag expands to full scale or 0
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic int pixel_w(input int color_w);
    return 3 * color_w;
  endfunction

  // Checker palette lookup, index is {tile_row_odd, tile_col_odd}
  function automatic logic [23:0] checker_color(input logic [1:0] idx);
    logic [23:0] c;
    case (idx)
      2'b00:   c = TURQUOISE;
      2'b01:   c = CARROT;
      2'b10:   c = SUNFLOWER;
      default: c = EMERALD;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] c;
    case (bar)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : video_pos_counter
//  Description : Raster position tracker for the pattern source. Holds x/y,
//                tile column/row sub-counters with parity and the colour-bar
//                sub-counter, all advanced by one position per enable. Exposes
//                the next-state position so the caller can register the pixel
//                for the upcoming position in the same cycle.
//  Ports       : Clock, Reset (sync, active-high), enable (transfer strobe)
//                x_next/y_next      next raster position
//                tile_x_odd/_y_odd  parity of next tile column/row
//                bar_next           next colour-bar index 0..7
//                eol_next/sof_next  next position is line end / frame start
//                frame_last         current position is the last of the frame
//  Revision    : 1.0  initial release
// ============================================================================
module video_pos_counter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 200,
  localparam int XW      = $clog2(H_ACTIVE),
  localparam int YW      = $clog2(V_ACTIVE)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          enable,
  output logic [XW-1:0] x_next,
  output logic [YW-1:0] y_next,
  output logic          tile_x_odd,
  output logic          tile_y_odd,
  output logic [2:0]    bar_next,
  output logic          eol_next,
  output logic          sof_next,
  output logic          frame_last
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int TXW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int TYW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int BW    = (BAR_W > 1)  ? $clog2(BAR_W)  : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(TILE_H - 1);
  localparam logic [BW-1:0]  B_LAST  = BW'(BAR_W - 1);

  logic [XW-1:0]  x,    x_nx;
  logic [YW-1:0]  y,    y_nx;
  logic [TXW-1:0] tcx,  tcx_nx;
  logic [TYW-1:0] tcy,  tcy_nx;
  logic           txo,  txo_nx;
  logic           tyo,  tyo_nx;
  logic [BW-1:0]  bcnt, bcnt_nx;
  logic [2:0]     bidx, bidx_nx;
  logic           line_end;

  assign line_end   = (x == X_LAST);
  assign frame_last = line_end && (y == Y_LAST);

  always_comb begin
    x_nx    = x;
    y_nx    = y;
    tcx_nx  = tcx;
    tcy_nx  = tcy;
    txo_nx  = txo;
    tyo_nx  = tyo;
    bcnt_nx = bcnt;
    bidx_nx = bidx;
    if (enable) begin
      if (line_end) begin
        // Line wrap: horizontal sub-counters restart, so a truncated last
        // tile never carries its parity into the next line.
        x_nx    = '0;
        tcx_nx  = '0;
        txo_nx  = 1'b0;
        bcnt_nx = '0;
        bidx_nx = 3'd0;
        if (y == Y_LAST) begin
          y_nx   = '0;
          tcy_nx = '0;
          tyo_nx = 1'b0;
        end else begin
          y_nx = y + 1'b1;
          if (tcy == TY_LAST) begin
            tcy_nx = '0;
            tyo_nx = ~tyo;
          end else begin
            tcy_nx = tcy + 1'b1;
          end
        end
      end else begin
        x_nx = x + 1'b1;
        if (tcx == TX_LAST) begin
          tcx_nx = '0;
          txo_nx = ~txo;
        end else begin
          tcx_nx = tcx + 1'b1;
        end
        if (bcnt == B_LAST) begin
          bcnt_nx = '0;
          bidx_nx = bidx + 3'd1;
        end else begin
          bcnt_nx = bcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x    <= '0;
      y    <= '0;
      tcx  <= '0;
      tcy  <= '0;
      txo  <= 1'b0;
      tyo  <= 1'b0;
      bcnt <= '0;
      bidx <= 3'd0;
    end else begin
      x    <= x_nx;
      y    <= y_nx;
      tcx  <= tcx_nx;
      tcy  <= tcy_nx;
      txo  <= txo_nx;
      tyo  <= tyo_nx;
      bcnt <= bcnt_nx;
      bidx <= bidx_nx;
    end
  end

  assign x_next     = x_nx;
  assign y_next     = y_nx;
  assign tile_x_odd = txo_nx;
  assign tile_y_odd = tyo_nx;
  assign bar_next   = bidx_nx;
  assign eol_next   = (x_nx == X_LAST);
  assign sof_next   = (x_nx == '0) && (y_nx == '0);

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Test-pattern video source. Streams H_ACTIVE x V_ACTIVE RGB
//                frames (checker, colour bars, solid, optional gradient) over
//                a valid/ready handshake with frame/line markers.
//  Ports       : Clock, Reset (sync, active-high)
//                Mode         pattern select, latched at frame boundaries
//                VideoReady   sink accepts current pixel
//                VideoValid   pixel valid (held high from first post-reset
//                             cycle)
//                video        pixel {R,G,B}, COLOR_W bits per channel
//                StartOfFrame high with pixel (0,0)
//                EndOfLine    high with pixel x = H_ACTIVE-1
//  Config      : PATGEN_GRADIENT_EN - when defined, mode 3 is an x/y gradient;
//                otherwise mode 3 is a solid fill identical to mode 2.
//  Revision    : 1.0  initial release
// ============================================================================
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 200,
  parameter int COLOR_W  = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [1:0]                    Mode,
  input  logic                          VideoReady,
  output logic                          VideoValid,
  output logic [pixel_w(COLOR_W)-1:0]   video,
  output logic                          StartOfFrame,
  output logic                          EndOfLine
);

  localparam int PIX_W = pixel_w(COLOR_W);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);

  logic [XW-1:0]    x_nx;
  logic [YW-1:0]    y_nx;
  logic             tx_odd, ty_odd;
  logic [2:0]       bar_nx;
  logic             eol_nx, sof_nx, frame_last;
  logic             xfer, load_mode;
  logic [1:0]       mode_r, mode_sel;
  logic [2:0]       bar_bits;
  logic [PIX_W-1:0] pix_nx;
  logic             unused_pos;

  // MSB-align an 8-bit reference channel to COLOR_W bits: pad low bits with
  // zeros when wider, drop low bits when narrower.
  function automatic logic [COLOR_W-1:0] align(input logic [7:0] c);
    logic [COLOR_W+7:0] t;
    t = {c, {COLOR_W{1'b0}}};
    return t[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic [PIX_W-1:0] palette(input logic [23:0] rgb);
    return {align(rgb[23:16]), align(rgb[15:8]), align(rgb[7:0])};
  endfunction

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H)
  ) u_pos (
    .Clock      (Clock),
    .Reset      (Reset),
    .enable     (xfer),
    .x_next     (x_nx),
    .y_next     (y_nx),
    .tile_x_odd (tx_odd),
    .tile_y_odd (ty_odd),
    .bar_next   (bar_nx),
    .eol_next   (eol_nx),
    .sof_next   (sof_nx),
    .frame_last (frame_last)
  );

  assign xfer = VideoValid && VideoReady;

  // The pattern for a frame is decided when its first pixel is produced:
  // either on the first cycle out of reset or on the last-pixel transfer.
  // The freshly sampled Mode is used directly so pixel (0,0) already
  // reflects it.
  assign load_mode = !VideoValid || (xfer && frame_last);
  assign mode_sel  = load_mode ? Mode : mode_r;

  assign bar_bits   = bar_rgb(bar_nx);
  assign unused_pos = ^{x_nx, y_nx};

  always_comb begin
    pix_nx = palette(TURQUOISE);
    case (mode_sel)
      MODE_CHECKER: pix_nx = palette(checker_color({ty_odd, tx_odd}));
      MODE_BARS:    pix_nx = {{COLOR_W{bar_bits[2]}},
                              {COLOR_W{bar_bits[1]}},
                              {COLOR_W{bar_bits[0]}}};
      MODE_SOLID:   pix_nx = palette(TURQUOISE);
      default: begin
`ifdef PATGEN_GRADIENT_EN
        pix_nx = {COLOR_W'(x_nx), COLOR_W'(y_nx),
                  COLOR_W'(1) << (COLOR_W - 1)};
`else
        pix_nx = palette(TURQUOISE);
`endif
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_r       <= MODE_CHECKER;
      VideoValid   <= 1'b0;
      video        <= '0;
      StartOfFrame <= 1'b0;
      EndOfLine    <= 1'b0;
    end else begin
      if (load_mode) begin
        mode_r <= Mode;
      end
      // Output stage reloads on the first cycle after reset and on every
      // transfer; otherwise it holds under backpressure.
      if (!VideoValid || VideoReady) begin
        VideoValid   <= 1'b1;
        video        <= pix_nx;
        StartOfFrame <= sof_nx;
        EndOfLine    <= eol_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_video_pattern_gen
//  Description : Directed self-checking bench for video_pattern_gen using a
//                reduced raster (160x8, 48x3 tiles, partial last tile) and a
//                division-based reference model for every produced pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_pattern_gen;

  localparam int H  = 160;
  localparam int V  = 8;
  localparam int TW = 48;
  localparam int TH = 3;

  localparam logic [23:0] C_TURQ = 24'h1ABC9C;
  localparam logic [23:0] C_CARR = 24'hE67E22;
  localparam logic [23:0] C_SUNF = 24'hF1C40F;
  localparam logic [23:0] C_EMER = 24'h2ECC71;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Mode  = 2'd0;
  logic        VideoReady = 1'b1;
  logic        VideoValid;
  logic [23:0] video;
  logic        StartOfFrame;
  logic        EndOfLine;

  int          checks = 0;
  int          errors = 0;
  int          bx = 0;
  int          by = 0;
  logic [1:0]  exp_mode = 2'd0;

  video_pattern_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .TILE_W   (TW),
    .TILE_H   (TH),
    .COLOR_W  (8)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Mode         (Mode),
    .VideoReady   (VideoReady),
    .VideoValid   (VideoValid),
    .video        (video),
    .StartOfFrame (StartOfFrame),
    .EndOfLine    (EndOfLine)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input logic [1:0] m, input int x, input int y);
    int idx;
    int b;
    logic [23:0] p;
    idx = ((y / TH) % 2) * 2 + ((x / TW) % 2);
    b   = x / (H / 8);
    p   = C_TURQ;
    case (m)
      2'd0: begin
        case (idx)
          0:       p = C_TURQ;
          1:       p = C_CARR;
          2:       p = C_SUNF;
          default: p = C_EMER;
        endcase
      end
      2'd1: begin
        case (b)
          0:       p = 24'hFFFFFF;
          1:       p = 24'hFFFF00;
          2:       p = 24'h00FFFF;
          3:       p = 24'h00FF00;
          4:       p = 24'hFF00FF;
          5:       p = 24'hFF0000;
          6:       p = 24'h0000FF;
          default: p = 24'h000000;
        endcase
      end
      2'd2: p = C_TURQ;
      default: begin
`ifdef PATGEN_GRADIENT_EN
        p = {8'(x), 8'(y), 8'h80};
`else
        p = C_TURQ;
`endif
      end
    endcase
    return p;
  endfunction

  // One clock after reset release: track the expected position and check
  // every output against the model.
  task automatic step();
    logic       xfer;
    logic [1:0] m_before;
    xfer     = VideoReady;
    m_before = Mode;
    @(posedge Clock);
    #1;
    if (xfer) begin
      if (bx == H - 1) begin
        bx = 0;
        if (by == V - 1) begin
          by       = 0;
          exp_mode = m_before;
        end else begin
          by++;
        end
      end else begin
        bx++;
      end
    end
    check("valid", VideoValid, 1);
    check($sformatf("pix(%0d,%0d)", bx, by), video, ref_pixel(exp_mode, bx, by));
    check($sformatf("eol(%0d,%0d)", bx, by), EndOfLine, (bx == H - 1));
    check($sformatf("sof(%0d,%0d)", bx, by), StartOfFrame, (bx == 0 && by == 0));
  endtask

  task automatic advance_to(input int x, input int y);
    int n;
    n = 0;
    while (!(bx == x && by == y) && n < 4 * H * V) begin
      step();
      n++;
    end
    check($sformatf("reach(%0d,%0d)", x, y), (bx == x && by == y), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_valid", VideoValid, 0);
    check("rst_video", video, 0);
    check("rst_sof", StartOfFrame, 0);
    check("rst_eol", EndOfLine, 0);

    // Release: first pixel (0,0) immediately, mode 0
    Reset = 1'b0;
    exp_mode = Mode;
    bx = 0;
    by = 0;
    @(posedge Clock);
    #1;
    check("first_valid", VideoValid, 1);
    check("first_pix", video, C_TURQ);
    check("first_sof", StartOfFrame, 1);
    check("first_eol", EndOfLine, 0);

    // Backpressure at the last pixel of the first tile
    advance_to(47, 0);
    check("x47", video, C_TURQ);
    VideoReady = 1'b0;
    repeat (5) begin
      step();
      check("hold_pix", video, C_TURQ);
      check("hold_x", bx, 47);
    end
    VideoReady = 1'b1;
    step();
    check("x48_pos", bx, 48);
    check("x48_carrot", video, C_CARR);

    // Tile columns including the truncated last tile, and line end
    advance_to(96, 0);
    check("x96", video, C_TURQ);
    advance_to(144, 0);
    check("x144_partial", video, C_CARR);
    advance_to(158, 0);
    check("x158_eol", EndOfLine, 0);
    step();
    check("x159_eol", EndOfLine, 1);
    check("x159_pix", video, C_CARR);
    step();
    check("line1_x0", video, C_TURQ);
    check("line1_eol", EndOfLine, 0);

    // Tile rows
    advance_to(0, 3);
    check("y3_sunflower", video, C_SUNF);
    advance_to(48, 3);
    check("y3_emerald", video, C_EMER);

    // Mode change mid-frame is deferred to the next frame
    advance_to(80, 4);
    Mode = 2'd1;
    advance_to(0, 6);
    check("y6_still_checker", video, C_TURQ);
    advance_to(159, 7);
    check("last_px_checker", video, C_CARR);
    step();
    check("bars_x0_white", video, 24'hFFFFFF);
    check("bars_sof", StartOfFrame, 1);
    advance_to(20, 0);
    check("bars_x20_yellow", video, 24'hFFFF00);
    advance_to(159, 0);
    check("bars_x159_black", video, 24'h000000);
    check("bars_eol", EndOfLine, 1);

    // Solid
    Mode = 2'd2;
    advance_to(0, 0);
    check("solid_x0", video, C_TURQ);
    advance_to(100, 5);
    check("solid_100_5", video, C_TURQ);

    // Mode 3
    Mode = 2'd3;
    advance_to(0, 0);
    advance_to(100, 5);
`ifdef PATGEN_GRADIENT_EN
    check("mode3_100_5", video, 24'h640580);
`else
    check("mode3_100_5", video, C_TURQ);
`endif

    // Mid-frame reset, then restart in bars mode latched at release
    advance_to(123, 5);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("mrst_valid", VideoValid, 0);
    check("mrst_video", video, 0);
    check("mrst_sof", StartOfFrame, 0);
    check("mrst_eol", EndOfLine, 0);
    Mode = 2'd1;
    Reset = 1'b0;
    exp_mode = 2'd1;
    bx = 0;
    by = 0;
    @(posedge Clock);
    #1;
    check("restart_valid", VideoValid, 1);
    check("restart_sof", StartOfFrame, 1);
    check("restart_pix", video, 24'hFFFFFF);
    advance_to(40, 0);
    check("restart_x40_cyan", video, 24'h00FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
